ts_word_packer: RTL and testbench

Packs a continuous stream of IN_W-bit transport-stream symbols into OUT_W-bit words for the DMA/AXIS path. PACK_MODE selects one of two packing schemes:
- Aligned: whole symbols per word, no straddling.
- Dense: bit-stream packing, symbols straddle word boundaries.

A synchronous output FIFO with ready/valid absorbs sink backpressure. The symbol source cannot stall, so overflow drops words and is counted.

---
 rtl/ts_pack_pkg.sv | 19 +
 rtl/sync_fwft_fifo.sv | 55 +++++
 rtl/ts_word_packer.sv | 150 +++++++++++++++
 tb/tb_ts_word_packer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pack_pkg.sv
// Shared constants and helpers for the transport-stream word packer.
package ts_pack_pkg;

   localparam int PACK_ALIGNED = 0;
   localparam int PACK_DENSE   = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Word record is {last, fill, data}, MSB to LSB.
   function automatic int word_w(input int out_w);
      return 1 + clog2(out_w + 1) + out_w;
   endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO: head is visible while non-empty, pops on rd_rdy.
// A write into a full FIFO is refused unless a read happens on the same edge.
module sync_fwft_fifo
   import ts_pack_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_vld,
   input  logic [W-1:0]              wr_dat,
   input  logic                      rd_rdy,
   output logic [W-1:0]              rd_dat,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(DEPTH+1)-1:0] level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] cnt;
   logic          do_wr;
   logic          do_rd;

   assign full  = (cnt == LW'(DEPTH));
   assign empty = (cnt == '0);
   assign do_rd = rd_rdy & ~empty;
   assign do_wr = wr_vld & (~full | do_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + LW'(do_wr) - LW'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   // Empty FIFO presents zeros rather than stale storage.
   assign rd_dat = empty ? '0 : mem[rd_ptr];
   assign level  = cnt;

endmodule

// File: rtl/ts_word_packer.sv
// Packs IN_W-bit symbols into OUT_W-bit words (aligned or dense); closed word -> m_valid in 2 cycles.
// Source cannot stall: a word pushed into a full FIFO without a pop is dropped and counted.
module ts_word_packer
   import ts_pack_pkg::*;
#(
   parameter int IN_W       = 10,
   parameter int OUT_W      = 32,
   parameter int PACK_MODE  = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic [IN_W-1:0]                in_data,
   input  logic                           in_last,
   output logic [OUT_W-1:0]               m_data,
   output logic [clog2(OUT_W+1)-1:0]      m_fill,
   output logic                           m_last,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   input  logic                           clear_err,
   output logic                           err_overflow,
   output logic [CNT_W-1:0]               drop_cnt
);

   localparam int FILL_W = clog2(OUT_W + 1);
   localparam int SUM_W  = clog2(2 * OUT_W + 1);
   localparam int WIDE_W = 2 * OUT_W;
   localparam int N_SYM  = OUT_W / IN_W;
   localparam int WORD_W = word_w(OUT_W);
   // Bit count at which a word closes: full width when dense, N whole symbols when aligned.
   localparam logic [SUM_W-1:0] FULL_BITS = (PACK_MODE == PACK_DENSE) ?
                                            SUM_W'(OUT_W) : SUM_W'(N_SYM * IN_W);

   typedef struct packed {
      logic              last;
      logic [FILL_W-1:0] fill;
      logic [OUT_W-1:0]  data;
   } word_t;

   logic [OUT_W-1:0]  acc, acc_nxt;
   logic [FILL_W-1:0] bits, bits_nxt;
   logic              flush_q, flush_nxt;
   logic [WIDE_W-1:0] wide;
   logic [SUM_W-1:0]  sum;
   logic              close_vld;
   word_t             close_word;
   logic              stg_vld;
   word_t             stg_word;
   word_t             head_dat;
   logic              fifo_full;
   logic              fifo_empty;
   logic              drop;

   always_comb begin
      wide       = WIDE_W'(acc) | (WIDE_W'(in_data) << bits);
      sum        = SUM_W'(bits) + SUM_W'(IN_W);
      acc_nxt    = acc;
      bits_nxt   = bits;
      flush_nxt  = 1'b0;
      close_vld  = 1'b0;
      close_word = '0;
      if (flush_q) begin
         // Residue goes out alone; a symbol arriving now opens a fresh accumulator.
         close_vld       = 1'b1;
         close_word.last = 1'b1;
         close_word.fill = bits;
         close_word.data = acc;
         acc_nxt         = '0;
         bits_nxt        = '0;
         if (in_valid) begin
            acc_nxt   = OUT_W'(in_data);
            bits_nxt  = FILL_W'(IN_W);
            flush_nxt = in_last;
         end
      end else if (in_valid) begin
         if (sum >= FULL_BITS) begin
            close_vld       = 1'b1;
            close_word.data = wide[OUT_W-1:0];
            close_word.fill = (PACK_MODE == PACK_DENSE) ? FILL_W'(OUT_W) : FILL_W'(sum);
            acc_nxt         = wide[WIDE_W-1:OUT_W];
            bits_nxt        = FILL_W'(sum - FULL_BITS);
            if (in_last) begin
               if (bits_nxt == '0) close_word.last = 1'b1;
               else                flush_nxt       = 1'b1;
            end
         end else if (in_last) begin
            close_vld       = 1'b1;
            close_word.data = wide[OUT_W-1:0];
            close_word.fill = FILL_W'(sum);
            close_word.last = 1'b1;
            acc_nxt         = '0;
            bits_nxt        = '0;
         end else begin
            acc_nxt  = wide[OUT_W-1:0];
            bits_nxt = FILL_W'(sum);
         end
      end
   end

   assign m_valid = ~fifo_empty;
   assign drop    = stg_vld & fifo_full & ~(m_valid & m_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc          <= '0;
         bits         <= '0;
         flush_q      <= 1'b0;
         stg_vld      <= 1'b0;
         stg_word     <= '0;
         err_overflow <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         acc      <= acc_nxt;
         bits     <= bits_nxt;
         flush_q  <= flush_nxt;
         stg_vld  <= close_vld;
         stg_word <= close_word;
         if (clear_err) begin
            err_overflow <= 1'b0;
            drop_cnt     <= '0;
         end else if (drop) begin
            err_overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   sync_fwft_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (stg_vld),
      .wr_dat (stg_word),
      .rd_rdy (m_ready),
      .rd_dat (head_dat),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   assign m_data = head_dat.data;
   assign m_fill = head_dat.fill;
   assign m_last = head_dat.last;

endmodule

// File: tb/tb_ts_word_packer.sv
// Bench for ts_word_packer: one aligned and one dense instance, IN_W=10, OUT_W=32.
module tb_ts_word_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  fill;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic            dense;
      logic [2:0]      n;
      logic [3:0][9:0] sym;
      logic            last;
      logic [1:0]      nw;
      logic [1:0][31:0] wd;
      logic [1:0][5:0] wf;
      logic [1:0]      wl;
   } vec_t;

   localparam int NV = 9;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_a, in_valid_d;
   logic [9:0]  in_data;
   logic        in_last;
   logic        clear_err;
   logic        m_ready_a, m_ready_d;
   logic [31:0] m_data_a, m_data_d;
   logic [5:0]  m_fill_a, m_fill_d;
   logic        m_last_a, m_last_d;
   logic        m_valid_a, m_valid_d;
   logic [4:0]  fifo_level_a, fifo_level_d;
   logic        err_overflow_a, err_overflow_d;
   logic [15:0] drop_cnt_a, drop_cnt_d;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q_a[$];
   exp_t q_d[$];
   vec_t vt[NV];

   always #5 clk = ~clk;

   ts_word_packer #(.IN_W(10), .OUT_W(32), .PACK_MODE(0), .FIFO_DEPTH(16), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_data(in_data), .in_last(in_last),
      .m_data(m_data_a), .m_fill(m_fill_a), .m_last(m_last_a), .m_valid(m_valid_a),
      .m_ready(m_ready_a), .fifo_level(fifo_level_a), .clear_err(clear_err),
      .err_overflow(err_overflow_a), .drop_cnt(drop_cnt_a)
   );

   ts_word_packer #(.IN_W(10), .OUT_W(32), .PACK_MODE(1), .FIFO_DEPTH(16), .CNT_W(16)) u_dut_d (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_data(in_data), .in_last(in_last),
      .m_data(m_data_d), .m_fill(m_fill_d), .m_last(m_last_d), .m_valid(m_valid_d),
      .m_ready(m_ready_d), .fifo_level(fifo_level_d), .clear_err(clear_err),
      .err_overflow(err_overflow_d), .drop_cnt(drop_cnt_d)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   task automatic mon();
      exp_t e;
      if (m_valid_a && m_ready_a) begin
         if (q_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_extra: actual word %0h fill %0d, required no word", m_data_a, m_fill_a);
         end else begin
            e = q_a.pop_front();
            chk("a_data", m_data_a, e.data);
            chk("a_fill", m_fill_a, e.fill);
            chk("a_last", m_last_a, e.last);
         end
      end
      if (m_valid_d && m_ready_d) begin
         if (q_d.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL d_extra: actual word %0h fill %0d, required no word", m_data_d, m_fill_d);
         end else begin
            e = q_d.pop_front();
            chk("d_data", m_data_d, e.data);
            chk("d_fill", m_fill_d, e.fill);
            chk("d_last", m_last_d, e.last);
         end
      end
   endtask

   // Outputs sampled on the falling edge; stimulus changes 1ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic va, input logic vd, input logic [9:0] d, input logic l);
      in_valid_a = va;
      in_valid_d = vd;
      in_data    = d;
      in_last    = l;
      tick();
      in_valid_a = 1'b0;
      in_valid_d = 1'b0;
      in_last    = 1'b0;
   endtask

   task automatic push_exp(input logic dense, input logic [31:0] d, input int f, input logic l);
      exp_t e;
      e.data = d;
      e.fill = 6'(f);
      e.last = l;
      if (dense) q_d.push_back(e);
      else       q_a.push_back(e);
   endtask

   task automatic drain(input string nm, input int max);
      int c;
      c = 0;
      while ((q_a.size() != 0 || q_d.size() != 0) && c < max) begin
         tick();
         c++;
      end
      n_tests++;
      if (q_a.size() != 0 || q_d.size() != 0) begin
         n_fail++;
         $display("FAIL %s: actual %0d/%0d words outstanding after %0d cycles, required 0/0",
                  nm, q_a.size(), q_d.size(), max);
      end
   endtask

   function automatic logic [9:0] sv(input int k);
      return 10'((k * 37 + 5) & 'h3FF);
   endfunction

   function automatic logic [31:0] word_of(input int k);
      return {2'b00, sv(k + 2), sv(k + 1), sv(k)};
   endfunction

   function automatic vec_t mk(input logic dense, input int n,
                               input logic [9:0] s0, input logic [9:0] s1,
                               input logic [9:0] s2, input logic [9:0] s3, input logic last,
                               input int nw, input logic [31:0] d0, input int f0, input logic l0,
                               input logic [31:0] d1, input int f1, input logic l1);
      vec_t v;
      v.dense  = dense;
      v.n      = 3'(n);
      v.sym[0] = s0; v.sym[1] = s1; v.sym[2] = s2; v.sym[3] = s3;
      v.last   = last;
      v.nw     = 2'(nw);
      v.wd[0]  = d0; v.wf[0] = 6'(f0); v.wl[0] = l0;
      v.wd[1]  = d1; v.wf[1] = 6'(f1); v.wl[1] = l1;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: actual time %0t, required completion earlier", $time);
      $fatal(1);
   end

   initial begin
      logic [159:0] bs;

      vt[0] = mk(0, 3, 10'h001, 10'h002, 10'h003, 10'h000, 0, 1, 32'h00300801, 30, 0, 0, 0, 0);
      vt[1] = mk(0, 1, 10'h155, 10'h000, 10'h000, 10'h000, 1, 1, 32'h00000155, 10, 1, 0, 0, 0);
      vt[2] = mk(0, 2, 10'h3FF, 10'h001, 10'h000, 10'h000, 1, 1, 32'h000007FF, 20, 1, 0, 0, 0);
      vt[3] = mk(0, 3, 10'h2AA, 10'h155, 10'h3FF, 10'h000, 0, 1, 32'h3FF556AA, 30, 0, 0, 0, 0);
      vt[4] = mk(0, 3, 10'h0AB, 10'h0CD, 10'h0EF, 10'h000, 1, 1, 32'h0EF334AB, 30, 1, 0, 0, 0);
      vt[5] = mk(1, 4, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1, 2, 32'hFFFFFFFF, 32, 0, 32'h000000FF, 8, 1);
      vt[6] = mk(1, 3, 10'h001, 10'h002, 10'h003, 10'h000, 1, 1, 32'h00300801, 30, 1, 0, 0, 0);
      vt[7] = mk(1, 4, 10'h3FF, 10'h000, 10'h000, 10'h2C5, 1, 2, 32'h400003FF, 32, 0, 32'h000000B1, 8, 1);
      vt[8] = mk(1, 2, 10'h0F0, 10'h00F, 10'h000, 10'h000, 1, 1, 32'h00003CF0, 20, 1, 0, 0, 0);

      rst_n      = 1'b0;
      in_valid_a = 1'b0;
      in_valid_d = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      clear_err  = 1'b0;
      m_ready_a  = 1'b1;
      m_ready_d  = 1'b1;
      #1;
      chk("rst_a_valid", m_valid_a, 0);
      chk("rst_a_level", fifo_level_a, 0);
      chk("rst_a_data", m_data_a, 0);
      chk("rst_a_fill", m_fill_a, 0);
      chk("rst_a_last", m_last_a, 0);
      chk("rst_a_err", err_overflow_a, 0);
      chk("rst_a_drop", drop_cnt_a, 0);
      chk("rst_d_valid", m_valid_d, 0);
      chk("rst_d_level", fifo_level_d, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Two-cycle latency from the closing symbol to m_valid.
      push_exp(0, 32'h00300801, 30, 0);
      drv(1, 0, 10'h001, 0);
      drv(1, 0, 10'h002, 0);
      drv(1, 0, 10'h003, 0);
      chk("lat_edge_t", m_valid_a, 0);
      tick();
      chk("lat_edge_t1", m_valid_a, 1);
      drain("drain_lat", 10);

      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < int'(vt[i].nw); j++)
            push_exp(vt[i].dense, vt[i].wd[j], int'(vt[i].wf[j]), vt[i].wl[j]);
         for (int k = 0; k < int'(vt[i].n); k++)
            drv(!vt[i].dense, vt[i].dense, vt[i].sym[k], vt[i].last && (k == int'(vt[i].n) - 1));
         repeat (3) tick();
      end
      drain("drain_table", 30);

      // Dense flush cycle with a new symbol arriving in that same cycle.
      push_exp(1, 32'hFFFFFFFF, 32, 0);
      push_exp(1, 32'h000000FF, 8, 1);
      push_exp(1, 32'h00000801, 20, 1);
      for (int k = 0; k < 4; k++) drv(0, 1, 10'h3FF, k == 3);
      drv(0, 1, 10'h001, 0);
      drv(0, 1, 10'h002, 1);
      drain("drain_flush", 20);

      // Dense run of 16 symbols ending on an exact word boundary.
      bs = '0;
      for (int k = 0; k < 16; k++) bs[k*10 +: 10] = sv(k + 200);
      for (int j = 0; j < 5; j++) push_exp(1, bs[j*32 +: 32], 32, j == 4);
      for (int k = 0; k < 16; k++) drv(0, 1, sv(k + 200), k == 15);
      drain("drain_exact", 20);

      // Overflow: 17 words into a 16-entry FIFO with the sink stalled.
      m_ready_a = 1'b0;
      for (int j = 0; j < 16; j++) push_exp(0, word_of(3 * j), 30, 0);
      for (int k = 0; k < 51; k++) drv(1, 0, sv(k), 0);
      repeat (3) tick();
      chk("ovf_level", fifo_level_a, 16);
      chk("ovf_drop_cnt", drop_cnt_a, 1);
      chk("ovf_err", err_overflow_a, 1);
      chk("ovf_head", m_data_a, q_a[0].data);
      tick();
      chk("ovf_head_hold", m_data_a, q_a[0].data);

      for (int k = 51; k < 54; k++) drv(1, 0, sv(k), 0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("clr_err", err_overflow_a, 0);
      chk("clr_drop_cnt", drop_cnt_a, 0);
      chk("clr_level", fifo_level_a, 16);

      for (int k = 54; k < 57; k++) drv(1, 0, sv(k), 0);
      push_exp(0, word_of(54), 30, 0);
      m_ready_a = 1'b1;
      tick();
      m_ready_a = 1'b0;
      chk("full_pp_level", fifo_level_a, 16);
      chk("full_pp_drop", drop_cnt_a, 0);
      chk("full_pp_err", err_overflow_a, 0);
      m_ready_a = 1'b1;
      drain("drain_ovf", 60);
      chk("ovf_end_level", fifo_level_a, 0);

      // Reset with a word queued and a partial word in the accumulator.
      m_ready_a = 1'b0;
      for (int k = 100; k < 103; k++) drv(1, 0, sv(k), 0);
      repeat (2) tick();
      chk("pre_rst_valid", m_valid_a, 1);
      drv(1, 0, 10'h3AA, 0);
      drv(1, 0, 10'h255, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid_a, 0);
      chk("mid_rst_level", fifo_level_a, 0);
      chk("mid_rst_data", m_data_a, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      m_ready_a = 1'b1;
      push_exp(0, 32'h03308811, 30, 0);
      drv(1, 0, 10'h011, 0);
      drv(1, 0, 10'h022, 0);
      drv(1, 0, 10'h033, 0);
      drain("drain_rst", 20);
      repeat (3) tick();
      chk("post_rst_level", fifo_level_a, 0);
      chk("post_rst_valid", m_valid_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
